// File: rtl/fp_normalizer_pkg.sv
// Shared FPU definitions for the post-add normalizer: widths, the exponent
// saturation value, the control state encoding and a sticky right-shift helper.
package fp_normalizer_pkg;

    localparam int EXP_W      = 8;
    localparam int FRAC_IN_W  = 26;
    localparam int FRAC_OUT_W = 25;

    localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

    // Bit positions inside the raw significand.
    localparam int CARRY_BIT  = FRAC_IN_W - 1;
    localparam int HIDDEN_BIT = FRAC_IN_W - 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Right shift by one that folds the two bits leaving the guard position
    // into the new guard bit, so no set bit below the LSB is ever lost.
    function automatic logic [FRAC_IN_W-1:0] shr_sticky(input logic [FRAC_IN_W-1:0] f);
        return {1'b0, f[FRAC_IN_W-1:2], f[1] | f[0]};
    endfunction

endpackage

// File: rtl/fp_normalizer_if.sv
// Operand/result handshake bundle between an adder back end (master) and the
// normalizer (slave).
interface fp_normalizer_if;
    import fp_normalizer_pkg::*;

    // Producer side
    logic                  in_valid;
    logic                  in_ready;
    logic [EXP_W-1:0]      exp_in;
    logic [FRAC_IN_W-1:0]  frac_in;
    logic                  flush;

    // Consumer side
    logic                  out_valid;
    logic                  out_ready;
    logic [EXP_W-1:0]      exp_out;
    logic [FRAC_OUT_W-1:0] frac_out;
    logic                  zero;
    logic                  ovf;
    logic                  denorm;

    modport master (
        output in_valid, exp_in, frac_in, flush, out_ready,
        input  in_ready, out_valid, exp_out, frac_out, zero, ovf, denorm
    );

    modport slave (
        input  in_valid, exp_in, frac_in, flush, out_ready,
        output in_ready, out_valid, exp_out, frac_out, zero, ovf, denorm
    );

endinterface

// File: rtl/fp_normalizer.sv
// Iterative significand normalizer: takes the raw exponent/significand of an
// add, walks the significand one position per cycle until the hidden bit is
// set (or the exponent bottoms out), and holds the result until consumed.
module fp_normalizer
    import fp_normalizer_pkg::*;
(
    input  logic          CLK,
    input  logic          nRST,
    fp_normalizer_if.slave bus
);

    state_e                 state_q, state_d;
    logic [EXP_W-1:0]       exp_q, exp_d;
    logic [FRAC_IN_W-1:0]   frac_q, frac_d;
    logic                   zero_q, zero_d;
    logic                   ovf_q, ovf_d;
    logic                   denorm_q, denorm_d;

    // Asserted in SHIFT when this cycle's action finishes the operand.
    logic                   step_done;
    logic                   accept;
    logic [FRAC_IN_W-1:0]   frac_shr;
    logic [EXP_W-1:0]       exp_inc;

    assign accept   = (state_q == ST_IDLE) && bus.in_valid;
    assign frac_shr = shr_sticky(frac_q);
    assign exp_inc  = exp_q + 8'd1;

    // State register.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush overrides every handshake.
    always_comb begin
        state_d = state_q;
        if (bus.flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  if (bus.in_valid)  state_d = ST_SHIFT;
                ST_SHIFT: if (step_done)     state_d = ST_DONE;
                ST_DONE:  if (bus.out_ready) state_d = ST_IDLE;
                default:                     state_d = ST_IDLE;
            endcase
        end
    end

    // Datapath registers holding the operand under normalization and the flags.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            exp_q    <= '0;
            frac_q   <= '0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            denorm_q <= 1'b0;
        end else begin
            exp_q    <= exp_d;
            frac_q   <= frac_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            denorm_q <= denorm_d;
        end
    end

    // One normalization action per SHIFT cycle, checked in priority order.
    always_comb begin
        exp_d     = exp_q;
        frac_d    = frac_q;
        zero_d    = zero_q;
        ovf_d     = ovf_q;
        denorm_d  = denorm_q;
        step_done = 1'b0;

        if (!bus.flush) begin
            if (accept) begin
                exp_d    = bus.exp_in;
                frac_d   = bus.frac_in;
                zero_d   = 1'b0;
                ovf_d    = 1'b0;
                denorm_d = 1'b0;
            end else if (state_q == ST_SHIFT) begin
                if (exp_q == EXP_MAX) begin
                    // Inf/NaN encodings are passed through untouched.
                    step_done = 1'b1;
                end else if (frac_q == '0) begin
                    exp_d     = '0;
                    zero_d    = 1'b1;
                    step_done = 1'b1;
                end else if (frac_q[CARRY_BIT]) begin
                    if (exp_inc == EXP_MAX) begin
                        exp_d  = EXP_MAX;
                        frac_d = '0;
                        ovf_d  = 1'b1;
                    end else begin
                        exp_d  = exp_inc;
                        frac_d = frac_shr;
                    end
                    step_done = 1'b1;
                end else if (frac_q[HIDDEN_BIT]) begin
                    step_done = 1'b1;
                end else if (exp_q <= 8'd1) begin
                    // Cannot shift further without leaving the exponent range.
                    exp_d     = '0;
                    denorm_d  = 1'b1;
                    step_done = 1'b1;
                end else begin
                    frac_d = {frac_q[FRAC_IN_W-2:0], 1'b0};
                    exp_d  = exp_q - 8'd1;
                end
            end
        end
    end

    // Handshake and result outputs, all driven straight from registers.
    always_comb begin
        bus.in_ready  = (state_q == ST_IDLE);
        bus.out_valid = (state_q == ST_DONE);
        bus.exp_out   = exp_q;
        bus.frac_out  = frac_q[FRAC_OUT_W-1:0];
        bus.zero      = zero_q;
        bus.ovf       = ovf_q;
        bus.denorm    = denorm_q;
    end

    // The carry bit never survives to DONE, so it is not part of the result.
    logic unused_carry;
    assign unused_carry = frac_q[CARRY_BIT] & 1'b0;

endmodule

// File: tb/tb_fp_normalizer.sv
// Self-checking bench for fp_normalizer: directed corner operands, random
// operands against a value-level reference model, output hold, flush and reset.
module tb_fp_normalizer;

    logic clk;
    logic nrst;

    int errors = 0;
    int checks = 0;

    fp_normalizer_if bus_if ();

    fp_normalizer dut (
        .CLK  (clk),
        .nRST (nrst),
        .bus  (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // Reference: result of normalizing a raw sum, from the arithmetic rules.
    // k is the number of left shifts taken; flags are {zero, ovf, denorm}.
    task automatic model(input logic [7:0] e, input logic [25:0] f,
                         output logic [7:0] eo, output logic [24:0] fo,
                         output logic [2:0] fl, output int k);
        logic [25:0] t;
        int p, need, avail;
        k  = 0;
        fl = 3'b000;
        if (e == 8'hFF) begin
            eo = e;
            fo = f[24:0];
        end else if (f == 26'd0) begin
            eo = 8'd0;
            fo = 25'd0;
            fl = 3'b100;
        end else if (f[25]) begin
            if (e == 8'hFE) begin
                eo = 8'hFF;
                fo = 25'd0;
                fl = 3'b010;
            end else begin
                t  = (f >> 1) | {25'd0, f[0]};
                eo = e + 8'd1;
                fo = t[24:0];
            end
        end else begin
            p = 0;
            for (int i = 0; i < 25; i++) if (f[i]) p = i;
            need  = 24 - p;
            avail = (e >= 8'd2) ? int'(e) - 1 : 0;
            if (need <= avail) begin
                k  = need;
                t  = f << need;
                eo = e - 8'(need);
                fo = t[24:0];
            end else begin
                k  = avail;
                t  = f << avail;
                eo = 8'd0;
                fo = t[24:0];
                fl = 3'b001;
            end
        end
    endtask

    task automatic run_op(input logic [7:0] e, input logic [25:0] f, input int hold);
        logic [7:0]  eo;
        logic [24:0] fo;
        logic [2:0]  fl;
        int k, n;
        model(e, f, eo, fo, fl, k);
        @(negedge clk);
        check("ready_idle", 32'(bus_if.in_ready), 32'd1);
        bus_if.in_valid = 1'b1;
        bus_if.exp_in   = e;
        bus_if.frac_in  = f;
        @(posedge clk);
        @(negedge clk);
        bus_if.in_valid = 1'b0;
        n = 0;
        while (!bus_if.out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        // Cycle t0+1 is the one right after the accept edge.
        check("latency", 32'(n + 1), 32'(2 + k));
        check("exp_out", 32'(bus_if.exp_out), 32'(eo));
        check("frac_out", 32'(bus_if.frac_out), 32'(fo));
        check("flags", 32'({bus_if.zero, bus_if.ovf, bus_if.denorm}), 32'(fl));
        check("ready_busy", 32'(bus_if.in_ready), 32'd0);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_valid", 32'(bus_if.out_valid), 32'd1);
            check("hold_data", 32'({bus_if.exp_out, bus_if.frac_out}), 32'({eo, fo}));
            check("hold_flags", 32'({bus_if.zero, bus_if.ovf, bus_if.denorm}), 32'(fl));
        end
        bus_if.out_ready = 1'b1;
        @(negedge clk);
        bus_if.out_ready = 1'b0;
        check("release_valid", 32'(bus_if.out_valid), 32'd0);
        check("release_ready", 32'(bus_if.in_ready), 32'd1);
        $display("op exp=%02h frac=%07h -> exp=%02h frac=%07h z=%0d o=%0d d=%0d k=%0d",
                 e, f, bus_if.exp_out, bus_if.frac_out,
                 bus_if.zero, bus_if.ovf, bus_if.denorm, k);
    endtask

    // Start a 16-shift operand, abort it after 'wait_cyc' cycles with flush or reset.
    task automatic abort_op(input bit use_reset, input int wait_cyc);
        bit saw_valid;
        @(negedge clk);
        bus_if.in_valid = 1'b1;
        bus_if.exp_in   = 8'h80;
        bus_if.frac_in  = 26'h0000100;
        @(negedge clk);
        bus_if.in_valid = 1'b0;
        for (int i = 0; i < wait_cyc; i++) @(negedge clk);
        if (use_reset) nrst = 1'b0;
        else           bus_if.flush = 1'b1;
        @(negedge clk);
        nrst = 1'b1;
        bus_if.flush = 1'b0;
        check(use_reset ? "rst_abort_ready" : "flush_abort_ready", 32'(bus_if.in_ready), 32'd1);
        check(use_reset ? "rst_abort_valid" : "flush_abort_valid", 32'(bus_if.out_valid), 32'd0);
        if (use_reset)
            check("rst_abort_outs",
                  32'({bus_if.exp_out, bus_if.frac_out[20:0], bus_if.zero, bus_if.ovf, bus_if.denorm}),
                  32'd0);
        saw_valid = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            saw_valid |= bus_if.out_valid;
        end
        check("no_valid_after_abort", 32'(saw_valid), 32'd0);
        $display("abort %s after %0d cycles", use_reset ? "reset" : "flush", wait_cyc);
    endtask

    initial begin
        logic [7:0]  re;
        logic [25:0] rf;
        int p;

        nrst             = 1'b0;
        bus_if.in_valid  = 1'b0;
        bus_if.exp_in    = 8'h00;
        bus_if.frac_in   = 26'd0;
        bus_if.flush     = 1'b0;
        bus_if.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        check("rst_ready", 32'(bus_if.in_ready), 32'd1);
        check("rst_valid", 32'(bus_if.out_valid), 32'd0);
        check("rst_exp", 32'(bus_if.exp_out), 32'd0);
        check("rst_frac", 32'(bus_if.frac_out), 32'd0);
        check("rst_flags", 32'({bus_if.zero, bus_if.ovf, bus_if.denorm}), 32'd0);
        $display("reset done");

        // Directed corners.
        run_op(8'h80, 26'h1000000, 0);
        run_op(8'h80, 26'h3000001, 0);
        run_op(8'h80, 26'h0000100, 0);
        run_op(8'h03, 26'h0200000, 0);
        run_op(8'hFE, 26'h2000000, 0);
        run_op(8'h55, 26'h0000000, 0);
        run_op(8'hFF, 26'h0001234, 0);
        run_op(8'h00, 26'h1000001, 0);
        run_op(8'h01, 26'h0400000, 0);
        run_op(8'h19, 26'h0000001, 0);
        run_op(8'h80, 26'h0123456, 5);

        // Aborts in SHIFT and in DONE.
        abort_op(1'b0, 5);
        abort_op(1'b1, 7);
        abort_op(1'b0, 20);
        abort_op(1'b1, 20);

        // Random operands spread over all leading-one positions and exponents.
        for (int i = 0; i < 60; i++) begin
            p = $urandom_range(0, 26);
            if (p == 26) rf = 26'd0;
            else         rf = 26'((1 << p) | ($urandom & ((1 << p) - 1)));
            case ($urandom_range(0, 3))
                0:       re = 8'($urandom_range(0, 4));
                1:       re = 8'($urandom_range(250, 255));
                default: re = 8'($urandom);
            endcase
            run_op(re, rf, $urandom_range(0, 2));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fp_normalizer.md
FP_NORMALIZER -- requirements
Module: fp_normalizer

Interface
REQ-001 The module SHALL use one clock and one reset; reset is synchronous and active-low.
REQ-002 CLK  input  1  rising-edge clock for all state.
REQ-003 nRST  input  1  synchronous active-low reset, sampled on CLK rising edge.
REQ-004 in_valid  input  1  producer presents an unnormalized operand.
REQ-005 in_ready  output  1  block can accept an operand; high only in IDLE.
REQ-006 exp_in  input  8  biased exponent of the raw sum.
REQ-007 frac_in  input  26  raw significand: bit25 carry, bit24 hidden, bits23:1 fraction, bit0 guard.
REQ-008 flush  input  1  abandons any operation in progress.
REQ-009 out_valid  output  1  normalized result is held on the outputs.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 exp_out  output  8  normalized biased exponent.
REQ-012 frac_out  output  25  normalized significand: bit24 hidden, bits23:1 fraction, bit0 guard.
REQ-013 zero  output  1  result is exact zero.
REQ-014 ovf  output  1  exponent overflowed to 8'hFF.
REQ-015 denorm  output  1  result is subnormal (exp_out 0 with hidden bit 0).

Function
REQ-016 The FSM SHALL have three states, IDLE, SHIFT and DONE; in_ready = (state==IDLE) and out_valid = (state==DONE).
REQ-017 In IDLE, in_valid&&in_ready SHALL capture exp_in/frac_in into internal registers, clear all flags, and move to SHIFT.
REQ-018 SHIFT SHALL perform exactly one action per cycle, in priority order: (a) frac==0 -> exp=0, zero=1, go to DONE; (b) frac[25]=1 -> frac>>1 with new bit0 = old bit1|old bit0 (sticky), exp+1, go to DONE; (c) frac[24]=1 -> go to DONE with no change; (d) exp<=1 -> exp=0, denorm=1, go to DONE with no shift; (e) otherwise frac<<1, exp-1, stay in SHIFT.
REQ-019 In case (b), if exp+1 reaches 8'hFF, the block SHALL set exp=8'hFF, frac=0 and ovf=1.
REQ-020 An operand with exp_in=8'hFF SHALL pass through unchanged (no shift) and go to DONE; NaN/Inf handling belongs upstream.
REQ-021 Latency: an operand accepted at edge t0 SHALL produce out_valid in cycle t0+2+k, where k is the number of left shifts (0..24).
REQ-022 exp_out, frac_out (internal bits24:0) and the flags SHALL be registered and stable while out_valid=1.
REQ-023 In DONE, out_ready=1 SHALL return the FSM to IDLE on the next edge; in_ready SHALL stay 0 until then, so there is no same-cycle accept.
REQ-024 flush=1 SHALL force IDLE at the next edge from any state, dropping the result; flush has priority over all handshakes.
REQ-025 frac_in[25] and frac_in[24] both set SHALL follow case (b).

Reset
REQ-026 nRST=0 SHALL set state=IDLE and exp_out=0, frac_out=0, zero=0, ovf=0, denorm=0, giving out_valid=0 and in_ready=1 in the following cycle.
REQ-027 Reset asserted mid-SHIFT or in DONE SHALL abandon the operation with no output handshake.

Structure
REQ-028 The state enum and the constants EXP_W=8, FRAC_IN_W=26, FRAC_OUT_W=25 and EXP_MAX=8'hFF SHALL live in the shared FPU package.
REQ-029 The block SHALL be a single module with no sub-module; the shifter is iterative, not a leading-zero counter.

Verification
REQ-030 exp_in=8'h80, frac_in=26'h1000000 -> out_valid at t0+2, exp_out=8'h80, frac_out=25'h1000000, all flags 0.
REQ-031 exp_in=8'h80, frac_in=26'h3000001 -> exp_out=8'h81, frac_out=25'h1800001 (sticky kept), out_valid at t0+2.
REQ-032 exp_in=8'h80, frac_in=26'h0000100 (k=16) -> exp_out=8'h70, frac_out=25'h1000000, out_valid at t0+18.
REQ-033 exp_in=8'h03, frac_in=26'h0200000 -> two shifts to exp=1, then denorm=1, exp_out=0, frac_out=25'h0800000.
REQ-034 exp_in=8'hFE with carry set -> ovf=1, exp_out=8'hFF, frac_out=0; separately, frac_in=0 -> zero=1, exp_out=0.
REQ-035 Hold out_ready=0 for 5 cycles -> outputs stable; flush or nRST=0 mid-SHIFT -> IDLE next edge with no out_valid pulse.
